// File: rtl/cla_32.sv
// 32-bit two-level carry-lookahead adder: combinational A + B + Cin with carry-out
// and signed overflow, plus a registered copy of all three results.
module cla_32 (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Cin,
    output logic [31:0] Sum,
    output logic        Cout,
    output logic        Ovf,
    output logic [31:0] Sum_q,
    output logic        Cout_q,
    output logic        Ovf_q
);

    // 4-wide lookahead cell shared by both levels: returns {G, P, c3, c2, c1}.
    // G and P do not depend on ci, so callers may pass 0 when only G/P are needed.
    function automatic logic [4:0] cla4_f(input logic [3:0] g, input logic [3:0] p,
                                          input logic ci);
        logic c1;
        logic c2;
        logic c3;
        logic gg;
        logic pp;
        c1 = g[0] | (p[0] & ci);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        pp = &p;
        return {gg, pp, c3, c2, c1};
    endfunction

    logic [31:0] g_s;
    logic [31:0] p_s;
    logic [31:0] c_s;
    logic [7:0]  grp_g_s;
    logic [7:0]  grp_p_s;
    logic [7:0]  grp_c_s;
    logic [1:0]  sec_g_s;
    logic [1:0]  sec_p_s;
    logic        c16_s;
    logic [31:0] sum_s;
    logic        cout_s;
    logic        ovf_s;

    logic [31:0] sum_r;
    logic        cout_r;
    logic        ovf_r;

    // Lookahead tree: bit g/p, group G/P, section G/P, then carries back down.
    always_comb begin
        logic [4:0] la_v;
        g_s     = A & B;
        p_s     = A ^ B;
        c_s     = 32'h0000_0000;
        grp_g_s = 8'h00;
        grp_p_s = 8'h00;
        grp_c_s = 8'h00;
        sec_g_s = 2'b00;
        sec_p_s = 2'b00;
        c16_s   = 1'b0;
        la_v    = 5'b00000;

        for (int k = 0; k < 8; k++) begin
            la_v       = cla4_f(g_s[4*k +: 4], p_s[4*k +: 4], 1'b0);
            grp_g_s[k] = la_v[4];
            grp_p_s[k] = la_v[3];
        end

        // Lower section first: its G/P produce c16, the carry-in of the upper section.
        la_v         = cla4_f(grp_g_s[3:0], grp_p_s[3:0], Cin);
        sec_g_s[0]   = la_v[4];
        sec_p_s[0]   = la_v[3];
        grp_c_s[0]   = Cin;
        grp_c_s[3:1] = la_v[2:0];
        c16_s        = sec_g_s[0] | (sec_p_s[0] & Cin);

        la_v         = cla4_f(grp_g_s[7:4], grp_p_s[7:4], c16_s);
        sec_g_s[1]   = la_v[4];
        sec_p_s[1]   = la_v[3];
        grp_c_s[4]   = c16_s;
        grp_c_s[7:5] = la_v[2:0];

        for (int k = 0; k < 8; k++) begin
            la_v                 = cla4_f(g_s[4*k +: 4], p_s[4*k +: 4], grp_c_s[k]);
            c_s[4*k]             = grp_c_s[k];
            c_s[4*k + 1 +: 3]    = la_v[2:0];
        end

        sum_s  = p_s ^ c_s;
        cout_s = sec_g_s[1] | (sec_p_s[1] & c16_s);
        ovf_s  = (A[31] == B[31]) && (sum_s[31] != A[31]);
    end

    // Pipeline copy of the result; cleared asynchronously, no enable.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sum_r  <= 32'h0000_0000;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            sum_r  <= sum_s;
            cout_r <= cout_s;
            ovf_r  <= ovf_s;
        end
    end

    assign Sum    = sum_s;
    assign Cout   = cout_s;
    assign Ovf    = ovf_s;
    assign Sum_q  = sum_r;
    assign Cout_q = cout_r;
    assign Ovf_q  = ovf_r;

endmodule

// File: tb/tb_cla_32.sv
// Self-checking bench for cla_32: directed vector table, reset sequence and random sweep,
// with registered results tracked through an expected-value queue.
module tb_cla_32;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic [31:0] A = 32'h0;
    logic [31:0] B = 32'h0;
    logic        Cin = 1'b0;
    logic [31:0] Sum;
    logic        Cout;
    logic        Ovf;
    logic [31:0] Sum_q;
    logic        Cout_q;
    logic        Ovf_q;

    cla_32 dut (
        .Clk(Clk), .Reset(Reset), .A(A), .B(B), .Cin(Cin),
        .Sum(Sum), .Cout(Cout), .Ovf(Ovf),
        .Sum_q(Sum_q), .Cout_q(Cout_q), .Ovf_q(Ovf_q)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t        vecs[13];
    logic [33:0] exp_q[$];   // {ovf, cout, sum}
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic cin);
        logic [32:0] s;
        logic        v;
        s = {1'b0, a} + {1'b0, b} + {32'h0, cin};
        v = (a[31] == b[31]) && (s[31] != a[31]);
        return {v, s};
    endfunction

    // Drive between edges, check combinational outputs, queue the registered expectation,
    // then check the registered outputs just after the next rising edge.
    task automatic apply(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic [33:0] exp);
        logic [33:0] e;
        @(negedge Clk);
        A = a; B = b; Cin = cin;
        #1;
        chk({name, "_comb"}, {Ovf, Cout, Sum}, exp);
        exp_q.push_back(exp);
        @(posedge Clk);
        #1;
        if (exp_q.size() == 0) begin
            chk({name, "_queue"}, 34'h0, 34'h1);
        end else begin
            e = exp_q.pop_front();
            chk({name, "_reg"}, {Ovf_q, Cout_q, Sum_q}, e);
        end
    endtask

    initial begin
        logic [33:0] e12;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rc;

        vecs[0]  = '{32'h0000_0000, 32'h0000_0004, 1'b0, 32'h0000_0004, 1'b0, 1'b0};
        vecs[1]  = '{32'h0040_0010, 32'h0000_0004, 1'b0, 32'h0040_0014, 1'b0, 1'b0};
        vecs[2]  = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vecs[3]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[4]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[5]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vecs[6]  = '{32'h0000_000F, 32'h0000_0001, 1'b0, 32'h0000_0010, 1'b0, 1'b0};
        vecs[7]  = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0};
        vecs[8]  = '{32'h0FFF_FFFF, 32'h0000_0001, 1'b0, 32'h1000_0000, 1'b0, 1'b0};
        vecs[9]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[10] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0};
        vecs[11] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[12] = '{32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0, 1'b0};

        // Reset held from time 0: registered outputs must read zero.
        #12;
        chk("reset_state", {Ovf_q, Cout_q, Sum_q}, 34'h0);
        @(posedge Clk);
        #1;
        chk("reset_held_edge", {Ovf_q, Cout_q, Sum_q}, 34'h0);
        @(negedge Clk);
        Reset = 1'b1;

        foreach (vecs[i]) begin
            apply($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                  {vecs[i].ovf, vecs[i].cout, vecs[i].sum});
        end

        // Asynchronous reset between edges, then reload after release.
        e12 = model(32'd5, 32'd6, 1'b1);
        apply("rst_pre", 32'd5, 32'd6, 1'b1, e12);
        #2;
        Reset = 1'b0;
        #1;
        chk("rst_async_clear", {Ovf_q, Cout_q, Sum_q}, 34'h0);
        chk("rst_comb_tracks", {Ovf, Cout, Sum}, e12);
        @(posedge Clk);
        #1;
        chk("rst_hold", {Ovf_q, Cout_q, Sum_q}, 34'h0);
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        chk("rst_release_noedge", {Ovf_q, Cout_q, Sum_q}, 34'h0);
        @(posedge Clk);
        #1;
        chk("rst_reload", {Ovf_q, Cout_q, Sum_q}, e12);

        for (int i = 0; i < 10000; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(1, 0));
            if (i % 4 == 1) ra = 32'hFFFF_FFFF ^ rb;   // long propagate chains
            apply("rand", ra, rb, rc, model(ra, rb, rc));
        end

        chk("queue_empty", 34'(exp_q.size()), 34'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
